// File: rtl/mux16_rr_sched_pkg.sv
// mux16_rr_sched_pkg: shared types and sizes for the round-robin mux scheduler
package mux16_rr_sched_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int N_REQ    = 16;
  localparam int SEL_W    = 4;
  localparam int HOLD_DEF = 4;
endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// rr_pick16: rotate-priority encoder, first set request after ptr (mod 16)
module rr_pick16
  import mux16_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] w,
  output logic             any
);
  // Scan farthest-first so the nearest candidate after ptr wins.
  always_comb begin
    w   = '0;
    any = |req;
    for (int i = N_REQ; i >= 1; i--)
      if (req[ptr + SEL_W'(i)]) w = ptr + SEL_W'(i);
  end
endmodule

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin owner of a 16:1 mux select with bounded grants and registered capture
module mux16_rr_sched
  import mux16_rr_sched_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic             x,
  output logic [SEL_W-1:0] s,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             dout,
  output logic             dvalid,
  output logic [SEL_W-1:0] dsrc
);
  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, w;
  logic [3:0]       cnt;
  logic             any, start, stop;

  rr_pick16 u_pick (.req(req), .ptr(ptr), .w(w), .any(any));

  always_comb begin
    start     = (state == IDLE) && en && any;
    stop      = (state == GRANT) && (!en || done || !req[s] || cnt == 4'(HOLD - 1));
    state_nxt = start ? GRANT : stop ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // Capture samples x from the grant cycle itself, so dvalid trails busy by one edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s      <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      ptr    <= '1;
      cnt    <= '0;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      dsrc   <= '0;
    end else begin
      if (start) begin
        s    <= w;
        gnt  <= N_REQ'(1) << w;
        ptr  <= w;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (state == GRANT) cnt <= cnt + 4'd1;
      if (stop) begin
        gnt  <= '0;
        busy <= 1'b0;
      end
      dvalid <= state == GRANT;
      if (state == GRANT) begin
        dout <= x;
        dsrc <= s;
      end
    end
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: randomized and directed checks against a behavioural owner/usage model
module tb_mux16_rr_sched;
  localparam int HOLD = 4;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, done = 1'b0, x = 1'b0;
  logic [15:0] req = '0;
  logic [3:0]  s, dsrc;
  logic [15:0] gnt;
  logic        busy, dout, dvalid;
  int          errors = 0, checks = 0;
  int          m_owner, m_ptr, m_used, m_s, m_dout, m_dvalid, m_dsrc;

  mux16_rr_sched #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done), .x(x),
    .s(s), .gnt(gnt), .busy(busy), .dout(dout), .dvalid(dvalid), .dsrc(dsrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("gnt", gnt, m_owner < 0 ? 16'h0 : 16'h1 << m_owner);
    chk("s", {12'h0, s}, 16'(m_s));
    chk("busy", {15'h0, busy}, 16'(m_owner >= 0));
    chk("dvalid", {15'h0, dvalid}, 16'(m_dvalid));
    chk("dout", {15'h0, dout}, 16'(m_dout));
    chk("dsrc", {12'h0, dsrc}, 16'(m_dsrc));
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 15; m_used = 0; m_s = 0;
    m_dout = 0; m_dvalid = 0; m_dsrc = 0;
  endtask

  // One clock edge of the scheduler, described by who owns the mux and for how long.
  task automatic model_edge();
    if (m_owner < 0) begin
      m_dvalid = 0;
      if (en && req != 0)
        for (int k = 1; k <= 16; k++) begin
          int c = (m_ptr + k) % 16;
          if (req[c]) begin
            m_owner = c; m_s = c; m_ptr = c; m_used = 1;
            break;
          end
        end
    end else begin
      m_dvalid = 1; m_dout = int'(x); m_dsrc = m_s;
      if (!en || done || !req[m_owner] || m_used == HOLD) m_owner = -1;
      else m_used++;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic e, input logic d);
    req = r; en = e; done = d; x = 1'($urandom);
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    model_reset();
    #4 check_all();
    #3 rst = 1'b1;
    for (int i = 0; i < 10; i++) step(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(16'h8005, 1'b1, 1'b0);
    async_reset();
    step(16'h0018, 1'b1, 1'b0);
    chk("early_owner", {12'h0, s}, 16'd3);
    step(16'h0018, 1'b1, 1'b0);
    step(16'h0018, 1'b1, 1'b1);
    chk("early_drop", gnt, 16'h0000);
    step(16'h0018, 1'b1, 1'b0);
    chk("early_next", {12'h0, s}, 16'd4);
    step(16'h0018, 1'b1, 1'b0);
    step(16'h0010, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(16'h0040, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(16'h0040, 1'b0, 1'b0);
    chk("en_block", {15'h0, busy}, 16'h0);
    async_reset();
    for (int i = 0; i < 2; i++) step(16'h0200, 1'b1, 1'b0);
    chk("pre_rst_owner", {12'h0, s}, 16'd9);
    async_reset();
    step(16'h0201, 1'b1, 1'b0);
    chk("post_rst_first", {12'h0, s}, 16'd0);
    r = 16'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) r = 16'($urandom & $urandom & $urandom);
      step(r, $urandom_range(0, 15) != 0, $urandom_range(0, 11) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares the 16:1 bit multiplexer datapath among 16 requesters.
- Grants one requester at a time and drives the mux select `s[3:0]`.
- Limits each grant to `HOLD` cycles.
- Captures the mux output `x` into a registered, valid-qualified stream.
- Sits between the requester request lines and the select port of the 16:1 mux; the mux itself stays outside this block.

## Interface
Parameters:
- `HOLD`, default 4: maximum grant length in cycles, legal range 1..16.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scheduler enable.
- `req`  in  16  request vector; bit n = requester n wants the mux.
- `done`  in  1  current owner releases early.
- `x`  in  1  mux output, already selected by `s`.
- `s`  out  4  mux select, registered.
- `gnt`  out  16  one-hot grant, registered; `gnt[s]` is the only bit set while granted.
- `busy`  out  1  high while in GRANT.
- `dout`  out  1  registered copy of `x`.
- `dvalid`  out  1  `dout` holds a sample taken under grant.
- `dsrc`  out  4  select value `dout` was sampled from.

## Operation
- FSM has two states: IDLE and GRANT.
- **Reset values:** state IDLE, `s`=0, `gnt`=0, `busy`=0, `dout`=0, `dvalid`=0, `dsrc`=0, pointer `ptr`=15, cycle count `cnt`=0.
- **IDLE:** `gnt`=0.
  - If `en` and `|req`, winner w = first set bit of `req` searching ptr+1, ptr+2, … mod 16.
  - At the edge: `s`<=w, `gnt`<=1<<w, `ptr`<=w, `cnt`<=0, go to GRANT.
  - Otherwise stay in IDLE; `s` holds its last value.
- **GRANT:** `cnt` increments each cycle.
  - Exit to IDLE at the edge where any of these holds: `~en`, `done`, `~req[s]`, or `cnt`==HOLD-1.
  - On exit: `gnt`<=0, `busy`<=0.
- **Capture:** every GRANT cycle, `dout`<=`x`, `dsrc`<=`s`, `dvalid`<=1 at the next edge. In all other cycles `dvalid`<=0 and `dout`/`dsrc` hold.
- **Width rules:** `cnt` is 4 bits; HOLD=16 exits at `cnt`==15. Pointer arithmetic is mod 16 (15+1 wraps to 0).
- **Boundary conditions:**
  - Single requester n with `req[n]` held: repeated grants to n of HOLD cycles each, separated by one IDLE cycle.
  - `req` all zero in IDLE: no grant, `s` unchanged.
  - `done` in the first GRANT cycle gives a 1-cycle grant.
  - `en` low in IDLE blocks arbitration.
  - `rst` asserted mid-grant: all outputs return to reset values immediately, without waiting for `clk`.

## Timing
- `req` sampled at edge k (in IDLE) → `gnt`/`s`/`busy` valid after edge k.
- A full grant lasts HOLD cycles. It is always followed by at least one cycle with `gnt`=0, which acts as a mux settle/turnaround cycle.
- `dvalid`/`dout` lag `busy` by exactly one cycle. `dvalid` is high for exactly as many cycles as `busy`.
- `s` only changes at the IDLE→GRANT edge, so it is stable throughout a grant.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, GRANT=1);
  - `N_REQ`=16 and `SEL_W`=4;
  - the default HOLD value.
- Natural sub-module: `rr_pick16`, a combinational rotate-priority encoder.
  - Inputs: `req[15:0]`, `ptr[3:0]`.
  - Outputs: `w[3:0]`, `any`.
  - The FSM, counter and capture registers stay in the top module.

## Test plan
- **Reset and idle:** reset, `en`=1, `req`=0 for 10 cycles → `gnt`=0, `busy`=0, `s`=0, `dvalid`=0 throughout.
- **Full-length grant:** HOLD=4, `req`=16'h0001 held → `gnt`=0001 for 4 cycles, one zero cycle, repeat. `dvalid` pulses of 4 cycles with `dsrc`=0 lagging by one cycle.
- **Rotation order:** `req`=16'h8005 held → grant order s=0, 2, 15, 0, 2… (wrap 15→0 verified).
- **Early release:** `done` pulsed in the 2nd GRANT cycle for s=3 → `gnt` drops after 2 cycles; next winner is the first requester after 3.
- **Request drop and enable drop:** `req[s]` cleared mid-grant → exit at the next edge. `en`=0 mid-grant → exit at the next edge, and no new grant while `en`=0.
- **Async reset mid-grant:** `rst` low between clock edges during GRANT with `s`=9 → `gnt`/`s`/`busy`/`dvalid` return to reset values immediately. After release, the first grant searches from 0.
